// File: rtl/axil_mem_sched.sv
// rtl/axil_mem_sched.sv - AXI-Lite to single-port byte-enabled memory scheduler
// Round-robin read/write arbitration, one access at a time, responses held until accepted.

package axil_mem_sched_pkg;
  localparam int unsigned AXIL_AW = 18;
  localparam int unsigned AXIL_DW = 64;

  typedef struct packed {
    logic [AXIL_AW-1:0] addr;
    logic [2:0]         prot;
  } axil_ax_t;

  typedef struct packed {
    logic [AXIL_DW-1:0]   data;
    logic [AXIL_DW/8-1:0] strb;
  } axil_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axil_b_t;

  typedef struct packed {
    logic [AXIL_DW-1:0] data;
    logic [1:0]         resp;
  } axil_r_t;

  typedef struct packed {
    axil_ax_t aw;
    logic     aw_valid;
    axil_w_t  w;
    logic     w_valid;
    logic     b_ready;
    axil_ax_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axil_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    axil_b_t b;
    logic    b_valid;
    logic    ar_ready;
    axil_r_t r;
    logic    r_valid;
  } axil_resp_t;
endpackage

module axil_mem_sched #(
  parameter int unsigned AW  = 18,
  parameter int unsigned DW  = 64,
  parameter int unsigned OFF = $clog2(DW/8),
  parameter int unsigned MAW = AW - OFF + 1,
  parameter type axil_req_t  = axil_mem_sched_pkg::axil_req_t,
  parameter type axil_resp_t = axil_mem_sched_pkg::axil_resp_t
) (
  input  logic            clk_i,
  input  logic            arst_ni,
  input  axil_req_t       req_i,
  output axil_resp_t      resp_o,
  output logic [MAW-1:0]  mem_addr_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, RD_DATA, R_RSP, B_RSP} state_e;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic rd_req, wr_req, grant_rd, grant_wr;

  assign rd_req   = req_i.ar_valid;
  assign wr_req   = req_i.aw_valid & req_i.w_valid;
  // prio_q=1 favours the write side when both are pending
  assign grant_wr = wr_req & (~rd_req | prio_q);
  assign grant_rd = rd_req & (~wr_req | ~prio_q);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    rdata_d     = rdata_q;
    resp_o      = '0;
    resp_o.r.data = rdata_q;
    mem_we_o    = 1'b0;
    mem_be_o    = req_i.w.strb;
    mem_wdata_o = req_i.w.data;
    mem_addr_o  = {req_i.ar.prot[1], req_i.ar.addr[AW-1:OFF]};

    unique case (state_q)
      IDLE: begin
        if (grant_rd) begin
          resp_o.ar_ready = 1'b1;
          prio_d          = 1'b1;
          state_d         = RD_DATA;
        end else if (grant_wr) begin
          resp_o.aw_ready = 1'b1;
          resp_o.w_ready  = 1'b1;
          mem_we_o        = 1'b1;
          mem_addr_o      = {req_i.aw.prot[1], req_i.aw.addr[AW-1:OFF]};
          prio_d          = 1'b0;
          state_d         = B_RSP;
        end
      end
      RD_DATA: begin
        rdata_d = mem_rdata_i;
        state_d = R_RSP;
      end
      R_RSP: begin
        resp_o.r_valid = 1'b1;
        if (req_i.r_ready) state_d = IDLE;
      end
      B_RSP: begin
        resp_o.b_valid = 1'b1;
        if (req_i.b_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_o = (state_q != IDLE);

  logic unused_ok;
  assign unused_ok = ^{req_i.aw.addr[OFF-1:0], req_i.ar.addr[OFF-1:0],
                       req_i.aw.prot[2], req_i.aw.prot[0],
                       req_i.ar.prot[2], req_i.ar.prot[0]};

endmodule

// File: tb/tb_axil_mem_sched.sv
// tb/tb_axil_mem_sched.sv - directed bench for axil_mem_sched
// Inputs change 1ns after the rising edge, outputs are checked 4ns after it.

module tb_axil_mem_sched;
  import axil_mem_sched_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  axil_req_t   req;
  axil_resp_t  resp;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  logic [63:0] mem [0:65535];

  always #5 clk = ~clk;

  axil_mem_sched dut (
    .clk_i      (clk),
    .arst_ni    (arst_n),
    .req_i      (req),
    .resp_o     (resp),
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_be_o   (mem_be),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .busy_o     (busy)
  );

  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 8; i++)
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    mem_rdata <= mem[mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    req    = '0;
    arst_n = 1'b0;
    tick();
    tick();
    #3;
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nvec++;
    if (resp !== '0) begin nerr++; $display("FAIL reset_resp: got %h expected 0", resp); end
    nvec++;
    if (mem_we !== 1'b0) begin nerr++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    tick();
    arst_n = 1'b1;
    #3;
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL release_busy: got %b expected 0", busy); end
    tick();
  endtask

  task automatic wr(input logic [17:0] addr, input logic [63:0] data, input logic [7:0] strb);
    req.aw.addr = addr; req.aw.prot = 3'b000; req.aw_valid = 1'b1;
    req.w.data = data;  req.w.strb = strb;    req.w_valid  = 1'b1;
    req.b_ready = 1'b0;
    #3;
    nvec++;
    if ({resp.aw_ready, resp.w_ready, mem_we} !== 3'b111) begin
      nerr++; $display("FAIL wr_grant: got %b expected 111", {resp.aw_ready, resp.w_ready, mem_we});
    end
    nvec++;
    if ({mem_addr, mem_be, mem_wdata} !== {1'b0, addr[17:3], strb, data}) begin
      nerr++; $display("FAIL wr_mem: got %h/%h/%h expected %h/%h/%h", mem_addr, mem_be, mem_wdata, {1'b0, addr[17:3]}, strb, data);
    end
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    #3;
    nvec++;
    if ({resp.b_valid, resp.b.resp, busy, mem_we} !== 5'b1_00_1_0) begin
      nerr++; $display("FAIL wr_bresp: got %b expected 10010", {resp.b_valid, resp.b.resp, busy, mem_we});
    end
    req.b_ready = 1'b1;
    tick();
    req.b_ready = 1'b0;
    #3;
    nvec++;
    if ({resp.b_valid, busy} !== 2'b00) begin
      nerr++; $display("FAIL wr_done: got %b expected 00", {resp.b_valid, busy});
    end
    tick();
  endtask

  task automatic rd(input logic [17:0] addr, input logic [63:0] exp);
    req.ar.addr = addr; req.ar.prot = 3'b000; req.ar_valid = 1'b1; req.r_ready = 1'b0;
    #3;
    nvec++;
    if ({resp.ar_ready, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b0, addr[17:3]}) begin
      nerr++; $display("FAIL rd_grant: got %b/%b/%h expected 1/0/%h", resp.ar_ready, mem_we, mem_addr, addr[17:3]);
    end
    tick();
    req.ar_valid = 1'b0;
    #3;
    nvec++;
    if (resp.r_valid !== 1'b0) begin nerr++; $display("FAIL rd_early: got %b expected 0", resp.r_valid); end
    tick();
    #3;
    nvec++;
    if ({resp.r_valid, resp.r.resp, resp.r.data} !== {1'b1, 2'b00, exp}) begin
      nerr++; $display("FAIL rd_data addr %h: got %b/%h expected 1/%h", addr, resp.r_valid, resp.r.data, exp);
    end
    req.r_ready = 1'b1;
    tick();
    req.r_ready = 1'b0;
    tick();
  endtask

  task automatic test_write_read;
    wr(18'h00008, 64'hDEADBEEF_01234567, 8'hFF);
    rd(18'h00008, 64'hDEADBEEF_01234567);
  endtask

  task automatic test_partial_write;
    wr(18'h00010, 64'hAAAAAAAA_BBBBBBBB, 8'hFF);
    wr(18'h00010, 64'h11111111_22222222, 8'h0F);
    rd(18'h00010, 64'hAAAAAAAA_22222222);
  endtask

  task automatic test_arbitration;
    logic grants [$];
    int   cyc;
    test_reset();
    req.ar.addr = 18'h00020; req.ar_valid = 1'b1;
    req.aw.addr = 18'h00028; req.w.data = 64'h0123_4567_89AB_CDEF; req.w.strb = 8'hFF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    req.r_ready = 1'b1; req.b_ready = 1'b1;
    cyc = 0;
    while (grants.size() < 16 && cyc < 200) begin
      #3;
      if (resp.ar_ready && resp.aw_ready) begin
        nvec++; nerr++; $display("FAIL arb_both: ar_ready and aw_ready together at cycle %0d", cyc);
      end
      if (resp.ar_ready) grants.push_back(1'b0);
      else if (resp.aw_ready) grants.push_back(1'b1);
      tick();
      cyc++;
    end
    req.ar_valid = 1'b0; req.aw_valid = 1'b0; req.w_valid = 1'b0;
    nvec++;
    if (grants.size() != 16) begin nerr++; $display("FAIL arb_count: got %0d grants expected 16", grants.size()); end
    for (int i = 0; i < grants.size(); i++) begin
      nvec++;
      if (grants[i] !== i[0]) begin nerr++; $display("FAIL arb_order[%0d]: got %b expected %b", i, grants[i], i[0]); end
    end
    tick(); tick(); tick();
    req.r_ready = 1'b0; req.b_ready = 1'b0;
    #3;
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL arb_drain: got busy %b expected 0", busy); end
    tick();
  endtask

  task automatic test_rready_stall;
    wr(18'h00030, 64'hCAFEF00D_5A5A5A5A, 8'hFF);
    req.ar.addr = 18'h00030; req.ar_valid = 1'b1; req.r_ready = 1'b0;
    tick();
    #3;
    nvec++;
    if (resp.ar_ready !== 1'b0) begin nerr++; $display("FAIL stall_rd_data_ar: got %b expected 0", resp.ar_ready); end
    tick();
    for (int i = 0; i < 5; i++) begin
      #3;
      nvec++;
      if ({resp.r_valid, resp.ar_ready, resp.r.data} !== {2'b10, 64'hCAFEF00D_5A5A5A5A}) begin
        nerr++; $display("FAIL stall[%0d]: got %b/%b/%h expected 1/0/cafef00d5a5a5a5a", i, resp.r_valid, resp.ar_ready, resp.r.data);
      end
      tick();
    end
    req.r_ready = 1'b1;
    tick();
    req.r_ready = 1'b0;
    #3;
    nvec++;
    if ({resp.ar_ready, resp.r_valid} !== 2'b10) begin
      nerr++; $display("FAIL stall_regrant: got %b expected 10", {resp.ar_ready, resp.r_valid});
    end
    tick();
    req.ar_valid = 1'b0;
    tick();
    req.r_ready = 1'b1;
    tick();
    req.r_ready = 1'b0;
    tick();
  endtask

  task automatic test_aw_without_w;
    req.aw.addr = 18'h00038; req.aw.prot = 3'b000; req.aw_valid = 1'b1;
    req.w.data = 64'h7777_8888_9999_AAAA; req.w.strb = 8'hFF; req.w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #3;
      nvec++;
      if ({resp.aw_ready, resp.w_ready, mem_we, busy} !== 4'b0000) begin
        nerr++; $display("FAIL aw_only[%0d]: got %b expected 0000", i, {resp.aw_ready, resp.w_ready, mem_we, busy});
      end
      tick();
    end
    req.aw_valid = 1'b0; req.w_valid = 1'b1;
    req.ar.addr = 18'h00008; req.ar_valid = 1'b1;
    #3;
    nvec++;
    if ({resp.ar_ready, resp.aw_ready, resp.w_ready, mem_we} !== 4'b1000) begin
      nerr++; $display("FAIL w_only_ar: got %b expected 1000", {resp.ar_ready, resp.aw_ready, resp.w_ready, mem_we});
    end
    tick();
    req.ar_valid = 1'b0; req.w_valid = 1'b0;
    tick();
    req.r_ready = 1'b1;
    tick();
    req.r_ready = 1'b0;
    req.aw_valid = 1'b1;
    tick();
    req.w_valid = 1'b1;
    #3;
    nvec++;
    if ({resp.aw_ready, resp.w_ready, mem_we} !== 3'b111) begin
      nerr++; $display("FAIL w_rise_grant: got %b expected 111", {resp.aw_ready, resp.w_ready, mem_we});
    end
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.b_ready = 1'b1;
    tick();
    req.b_ready = 1'b0;
    tick();
    rd(18'h00038, 64'h7777_8888_9999_AAAA);
  endtask

  task automatic test_reset_mid;
    wr(18'h00040, 64'h0BADC0DE_13579BDF, 8'hFF);
    req.ar.addr = 18'h00040; req.ar_valid = 1'b1; req.r_ready = 1'b0;
    tick();
    req.ar_valid = 1'b0;
    tick();
    #3;
    nvec++;
    if (resp.r_valid !== 1'b1) begin nerr++; $display("FAIL mid_rrsp: got %b expected 1", resp.r_valid); end
    #2;
    arst_n = 1'b0;
    #1;
    nvec++;
    if ({resp.r_valid, busy} !== 2'b00) begin
      nerr++; $display("FAIL mid_async_drop: got %b expected 00", {resp.r_valid, busy});
    end
    tick();
    arst_n = 1'b1;
    #3;
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL mid_release_busy: got %b expected 0", busy); end
    tick();
    req.ar.addr = 18'h00040; req.ar_valid = 1'b1;
    req.aw.addr = 18'h00048; req.w.data = 64'h2468_ACE0_1357_9BDF; req.w.strb = 8'hFF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    #3;
    nvec++;
    if ({resp.ar_ready, resp.aw_ready, resp.w_ready} !== 3'b100) begin
      nerr++; $display("FAIL mid_prio_reset: got %b expected 100", {resp.ar_ready, resp.aw_ready, resp.w_ready});
    end
    tick();
    req.ar_valid = 1'b0;
    #3;
    nvec++;
    if (resp.aw_ready !== 1'b0) begin nerr++; $display("FAIL mid_busy_aw: got %b expected 0", resp.aw_ready); end
    tick();
    #3;
    nvec++;
    if ({resp.r_valid, resp.r.data} !== {1'b1, 64'h0BADC0DE_13579BDF}) begin
      nerr++; $display("FAIL mid_reread: got %b/%h expected 1/0badc0de13579bdf", resp.r_valid, resp.r.data);
    end
    req.r_ready = 1'b1;
    tick();
    req.r_ready = 1'b0;
    #3;
    nvec++;
    if ({resp.aw_ready, mem_we, mem_addr} !== {2'b11, 16'h0009}) begin
      nerr++; $display("FAIL mid_next_write: got %b/%b/%h expected 1/1/0009", resp.aw_ready, mem_we, mem_addr);
    end
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    #3;
    nvec++;
    if (resp.b_valid !== 1'b1) begin nerr++; $display("FAIL mid_bresp: got %b expected 1", resp.b_valid); end
    req.b_ready = 1'b1;
    tick();
    req.b_ready = 1'b0;
    tick();
    rd(18'h00048, 64'h2468_ACE0_1357_9BDF);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    req = '0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_arbitration();
    test_rready_stall();
    test_aw_without_w();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000ns");
    $fatal(1);
  end

endmodule
